// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, fetch request FSM, and the IF/ID
// pipeline register. A stalled fetch that has already received its word parks
// it in a hold buffer so the memory is not re-read. A redirect that arrives
// while the PC cannot advance is remembered until the next advance.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h00003000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Redirect,
    input  logic [31:0] NPC,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemRdy,
    input  logic [31:0] IMemData,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PC4,
    output logic        IF_ID_Valid
);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]  state_reg;
    logic [31:0] pc_reg;
    logic        pend_reg;
    logic [31:0] pend_tgt_reg;
    logic [31:0] hold_instr_reg;
    logic [31:0] hold_pc4_reg;
    logic [31:0] instr_reg;
    logic [31:0] pc4_reg;
    logic        valid_reg;

    logic [31:0] pc4;
    logic        have_tgt;
    logic [31:0] tgt;
    logic        advance;
    logic [31:0] next_pc;

    // Sequential PC, redirect-target selection and the advance condition.
    // A live Redirect pulse always wins over an older pending target.
    always_comb begin
        pc4      = pc_reg + 32'd4;
        have_tgt = Redirect | pend_reg;
        tgt      = Redirect ? NPC : pend_tgt_reg;
        next_pc  = have_tgt ? tgt : pc4;
        advance  = !Flush && !Stall &&
                   ((state_reg == HOLD) || ((state_reg == FETCH) && IMemRdy));
    end

    // FSM, PC, pending redirect, hold buffer and IF/ID register.
    // Flush dominates everything except reset; Redirect never kills the
    // word being fetched, so the delay-slot instruction still lands in IF/ID.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= FETCH;
            pc_reg         <= RESET_PC;
            pend_reg       <= 1'b0;
            pend_tgt_reg   <= 32'd0;
            hold_instr_reg <= 32'd0;
            hold_pc4_reg   <= 32'd0;
            instr_reg      <= 32'd0;
            pc4_reg        <= 32'd0;
            valid_reg      <= 1'b0;
        end else if (Flush) begin
            state_reg      <= FETCH;
            hold_instr_reg <= 32'd0;
            hold_pc4_reg   <= 32'd0;
            instr_reg      <= 32'd0;
            pc4_reg        <= 32'd0;
            valid_reg      <= 1'b0;
            pend_reg       <= 1'b0;
            if (have_tgt) begin
                pc_reg <= tgt;
            end
        end else if (advance) begin
            // Word comes from the hold buffer when parked, else straight
            // from memory.
            instr_reg <= (state_reg == HOLD) ? hold_instr_reg : IMemData;
            pc4_reg   <= (state_reg == HOLD) ? hold_pc4_reg   : pc4;
            valid_reg <= 1'b1;
            pc_reg    <= next_pc;
            pend_reg  <= 1'b0;
            state_reg <= FETCH;
        end else begin
            // No advance: remember the newest redirect target.
            if (Redirect) begin
                pend_reg     <= 1'b1;
                pend_tgt_reg <= NPC;
            end
            if (state_reg == FETCH) begin
                if (IMemRdy) begin
                    // Word arrived under Stall: park it and stop requesting.
                    hold_instr_reg <= IMemData;
                    hold_pc4_reg   <= pc4;
                    state_reg      <= HOLD;
                end else if (!Stall) begin
                    // Memory not ready and decode wants more: insert a bubble.
                    instr_reg <= 32'd0;
                    valid_reg <= 1'b0;
                end
            end
        end
    end

    assign IMemReq     = (state_reg == FETCH);
    assign IMemAddr    = pc_reg;
    assign PC          = pc_reg;
    assign IF_ID_Instr = instr_reg;
    assign IF_ID_PC4   = pc4_reg;
    assign IF_ID_Valid = valid_reg;

endmodule
